// File: rtl/tdc_thermo_encoder.sv
// rtl/tdc_thermo_encoder.sv - carry-chain thermometer sampler, bubble corrector and fine/coarse timestamp encoder
module tdc_thermo_encoder #(
  parameter int N        = 32,
  parameter int FINE_W   = 6,
  parameter int COARSE_W = 16
) (
  input  logic                clk,
  input  logic                clrn,
  input  logic [N-1:0]        thermo,
  input  logic                enable,
  output logic                valid,
  output logic [FINE_W-1:0]   fine,
  output logic [COARSE_W-1:0] coarse,
  output logic                overflow,
  output logic [15:0]         hit_count
);

  // S0 sync stage and hit detect
  logic [N-1:0]        t0_q, t0_d;
  logic                prev0_q, prev0_d;
  logic                arm_q, arm_d;
  logic                hit;

  // free-running coarse counter
  logic [COARSE_W-1:0] cnt_q, cnt_d;

  // S1 bubble-corrected word
  logic [N-1:0]        c_q, c_d;
  logic                hit_s1_q, hit_s1_d;
  logic [COARSE_W-1:0] coarse_s1_q, coarse_s1_d;

  // S2 encoded edge position
  logic [FINE_W-1:0]   fine_s2_q, fine_s2_d;
  logic                ovf_s2_q, ovf_s2_d;
  logic                hit_s2_q, hit_s2_d;
  logic [COARSE_W-1:0] coarse_s2_q, coarse_s2_d;

  // S3 registered outputs
  logic                valid_q, valid_d;
  logic [FINE_W-1:0]   fine_q, fine_d;
  logic [COARSE_W-1:0] coarse_q, coarse_d;
  logic                overflow_q, overflow_d;
  logic [15:0]         hit_count_q, hit_count_d;

  // t0 with the virtual taps: t0[-1] = 1 below, t0[N] = 0 above
  logic [N+1:0]        t0_ext;

  // S0 next state: arm_q keeps prev0 high for the first edge after reset,
  // so a chain already high at release does not look like a rising edge
  always_comb begin
    t0_d    = thermo;
    prev0_d = arm_q ? t0_q[0] : 1'b1;
    arm_d   = 1'b1;
    cnt_d   = cnt_q + COARSE_W'(1);
    hit     = enable & t0_q[0] & ~prev0_q;
  end

  // S1 next state: 3-tap majority vote removes single-tap bubbles
  always_comb begin
    t0_ext      = {1'b0, t0_q, 1'b1};
    c_d         = '0;
    for (int i = 0; i < N; i++) begin
      c_d[i] = (t0_ext[i] & t0_ext[i+1]) | (t0_ext[i] & t0_ext[i+2]) |
               (t0_ext[i+1] & t0_ext[i+2]);
    end
    hit_s1_d    = hit;
    coarse_s1_d = hit ? cnt_q : coarse_s1_q;
  end

  // S2 next state: lowest zero wins, surviving islands above it are ignored
  always_comb begin
    fine_s2_d = FINE_W'(N);
    ovf_s2_d  = 1'b1;
    for (int i = N - 1; i >= 0; i--) begin
      if (!c_q[i]) begin
        fine_s2_d = FINE_W'(i);
        ovf_s2_d  = 1'b0;
      end
    end
    hit_s2_d    = hit_s1_q;
    coarse_s2_d = coarse_s1_q;
  end

  // S3 next state: load outputs on a hit, otherwise hold and drop valid
  always_comb begin
    valid_d     = hit_s2_q;
    fine_d      = fine_q;
    coarse_d    = coarse_q;
    overflow_d  = overflow_q;
    hit_count_d = hit_count_q;
    if (hit_s2_q) begin
      fine_d      = fine_s2_q;
      coarse_d    = coarse_s2_q;
      overflow_d  = ovf_s2_q;
      hit_count_d = hit_count_q + 16'd1;
    end
  end

  // S0 registers and coarse counter
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      t0_q    <= '0;
      prev0_q <= 1'b1;
      arm_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      t0_q    <= t0_d;
      prev0_q <= prev0_d;
      arm_q   <= arm_d;
      cnt_q   <= cnt_d;
    end
  end

  // S1 and S2 pipeline registers
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      c_q         <= '0;
      hit_s1_q    <= 1'b0;
      coarse_s1_q <= '0;
      fine_s2_q   <= '0;
      ovf_s2_q    <= 1'b0;
      hit_s2_q    <= 1'b0;
      coarse_s2_q <= '0;
    end else begin
      c_q         <= c_d;
      hit_s1_q    <= hit_s1_d;
      coarse_s1_q <= coarse_s1_d;
      fine_s2_q   <= fine_s2_d;
      ovf_s2_q    <= ovf_s2_d;
      hit_s2_q    <= hit_s2_d;
      coarse_s2_q <= coarse_s2_d;
    end
  end

  // S3 output registers
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      valid_q     <= 1'b0;
      fine_q      <= '0;
      coarse_q    <= '0;
      overflow_q  <= 1'b0;
      hit_count_q <= '0;
    end else begin
      valid_q     <= valid_d;
      fine_q      <= fine_d;
      coarse_q    <= coarse_d;
      overflow_q  <= overflow_d;
      hit_count_q <= hit_count_d;
    end
  end

  assign valid     = valid_q;
  assign fine      = fine_q;
  assign coarse    = coarse_q;
  assign overflow  = overflow_q;
  assign hit_count = hit_count_q;

endmodule
